// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: source ids and burst-counter sizing shared by the arbiter
package mux_rr_arbiter_pkg;
    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction
endpackage

// File: rtl/mux_rr_arbiter_ymux.sv
// yMux: SIZE-bit 2:1 mux, z = c ? b : a
module yMux #(
    parameter int SIZE = 32
) (
    output logic [SIZE-1:0] z,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            c
);
    assign z = c ? b : a;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-source bounded-burst round-robin arbiter over a shared yMux with registered output
//   in0/in1_valid,data,ready : requester handshakes (at most one ready per cycle)
//   out_valid,data,src,ready : registered selected word, its source, downstream handshake
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int MAX_BURST = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in0_valid,
    input  logic [SIZE-1:0] in0_data,
    output logic            in0_ready,
    input  logic            in1_valid,
    input  logic [SIZE-1:0] in1_data,
    output logic            in1_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic            out_src,
    input  logic            out_ready
);
    localparam int CW = cnt_w(MAX_BURST);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
    logic            run;
    logic            cur;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            any;
    logic            sel;
    logic [SIZE-1:0] mux_out;
    yMux #(.SIZE(SIZE)) u_mux (.z(mux_out), .a(in0_data), .b(in1_data), .c(sel));
    // run holds readies low from reset until the first edge after release
    always_comb begin
        accept    = run && (!out_valid || out_ready);
        any       = in0_valid || in1_valid;
        sel       = (in0_valid && in1_valid) ? ((cnt < CMAX) ? cur : !cur) : in1_valid;
        in0_ready = accept && in0_valid && sel == SRC_0;
        in1_ready = accept && in1_valid && sel == SRC_1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            cur       <= SRC_1;
            cnt       <= CMAX;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                out_valid <= any;
                if (any) begin
                    out_data <= mux_out;
                    out_src  <= sel;
                    cur      <= sel;
                    cnt      <= (sel != cur) ? CW'(1) : (cnt < CMAX) ? cnt + 1'b1 : CMAX;
                end else begin
                    // an idle cycle closes the burst so the next tie switches source
                    cnt <= CMAX;
                end
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for mux_rr_arbiter with MAX_BURST=2 (a_*) and MAX_BURST=1 (b_*)
module tb_mux_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in0_valid = 1'b0;
    logic        in1_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in0_data = '0;
    logic [31:0] in1_data = '0;
    logic        a_r0, a_r1, a_v, a_s;
    logic [31:0] a_d;
    logic        b_r0, b_r1, b_v, b_s;
    logic [31:0] b_d;
    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] qa[$];
    logic [32:0] qb[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.SIZE(32), .MAX_BURST(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(a_r0),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(a_r1),
        .out_valid(a_v), .out_data(a_d), .out_src(a_s), .out_ready(out_ready)
    );

    mux_rr_arbiter #(.SIZE(32), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(b_r0),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(b_r1),
        .out_valid(b_v), .out_data(b_d), .out_src(b_s), .out_ready(out_ready)
    );

    task automatic do_reset();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #2;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        in0_data  = 32'hDEAD0000;
        in1_data  = 32'hBEEF0000;
        repeat (2) begin
            @(posedge clk); #1;
            n_vec++;
            if ({a_v, a_s, a_d, a_r0, a_r1, b_r0, b_r1} !== '0) begin
                n_err++;
                $display("FAIL reset_state: got v=%b src=%b data=%h rdy=%b%b/%b%b want all zero", a_v, a_s, a_d, a_r0, a_r1, b_r0, b_r1);
            end
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({a_r0, a_r1, b_r0, b_r1} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b%b/%b%b want 00/00", a_r0, a_r1, b_r0, b_r1);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({a_r0, a_r1, b_r0, b_r1} !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_first_tie: got %b%b/%b%b want 10/10", a_r0, a_r1, b_r0, b_r1);
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [32:0] e;
        in0_valid = 1'b1;
        in1_valid = 1'b0;
        in0_data  = 32'hA5A5A5A5;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if ({a_r0, a_r1} !== 2'b10) begin
            n_err++;
            $display("FAIL single_ready: got %b%b want 10", a_r0, a_r1);
        end
        qa.push_back({1'b0, 32'hA5A5A5A5});
        @(posedge clk); #1;
        in0_valid = 1'b0;
        n_vec++;
        if (qa.size() == 0) begin
            n_err++;
            $display("FAIL single_out: scoreboard empty");
        end else begin
            e = qa.pop_front();
            if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL single_out: got v=%b src=%b data=%h want v=1 src=%b data=%h", a_v, a_s, a_d, e[32], e[31:0]);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (a_v !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: got v=%b want 0", a_v);
        end
    endtask

    task automatic test_contention();
        logic [5:0]  seq_a = 6'b001100;
        logic [5:0]  seq_b = 6'b101010;
        logic [32:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in0_valid = 1'b1;
            in1_valid = 1'b1;
            out_ready = 1'b1;
            in0_data  = 32'h10000000 + i;
            in1_data  = 32'h20000000 + i;
            #1;
            n_vec++;
            if ({a_r0, a_r1, b_r0, b_r1} !== {!seq_a[i], seq_a[i], !seq_b[i], seq_b[i]}) begin
                n_err++;
                $display("FAIL contention_ready[%0d]: got %b%b/%b%b want %b%b/%b%b", i, a_r0, a_r1, b_r0, b_r1, !seq_a[i], seq_a[i], !seq_b[i], seq_b[i]);
            end
            qa.push_back({seq_a[i], seq_a[i] ? in1_data : in0_data});
            qb.push_back({seq_b[i], seq_b[i] ? in1_data : in0_data});
            @(posedge clk); #1;
            n_vec++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL contention_a[%0d]: scoreboard empty", i);
            end else begin
                e = qa.pop_front();
                if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                    n_err++;
                    $display("FAIL contention_a[%0d]: got v=%b src=%b data=%h want v=1 src=%b data=%h", i, a_v, a_s, a_d, e[32], e[31:0]);
                end
            end
            n_vec++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL contention_b[%0d]: scoreboard empty", i);
            end else begin
                e = qb.pop_front();
                if ({b_v, b_s, b_d} !== {1'b1, e}) begin
                    n_err++;
                    $display("FAIL contention_b[%0d]: got v=%b src=%b data=%h want v=1 src=%b data=%h", i, b_v, b_s, b_d, e[32], e[31:0]);
                end
            end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [32:0] e = '0;
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 32'h11111111;
        in1_data  = 32'h22222222;
        qa.push_back({1'b0, 32'h11111111});
        @(posedge clk); #1;
        n_vec++;
        if (qa.size() == 0) begin
            n_err++;
            $display("FAIL bp_first: scoreboard empty");
        end else begin
            e = qa.pop_front();
            if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL bp_first: got v=%b src=%b data=%h want v=1 src=%b data=%h", a_v, a_s, a_d, e[32], e[31:0]);
            end
        end
        out_ready = 1'b0;
        in0_data  = 32'h33333333;
        in1_data  = 32'h44444444;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({a_r0, a_r1} !== 2'b00) begin
                n_err++;
                $display("FAIL bp_stall_ready[%0d]: got %b%b want 00", i, a_r0, a_r1);
            end
            @(posedge clk); #1;
            n_vec++;
            if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL bp_stall_hold[%0d]: got v=%b src=%b data=%h want v=1 src=%b data=%h", i, a_v, a_s, a_d, e[32], e[31:0]);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if ({a_r0, a_r1} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b%b want 10", a_r0, a_r1);
        end
        qa.push_back({1'b0, 32'h33333333});
        @(posedge clk); #1;
        n_vec++;
        if (qa.size() == 0) begin
            n_err++;
            $display("FAIL bp_reload: scoreboard empty");
        end else begin
            e = qa.pop_front();
            if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL bp_reload: got v=%b src=%b data=%h want v=1 src=%b data=%h", a_v, a_s, a_d, e[32], e[31:0]);
            end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic test_idle_closes();
        logic [32:0] e;
        do_reset();
        in0_valid = 1'b1;
        in0_data  = 32'h55555555;
        qa.push_back({1'b0, 32'h55555555});
        @(posedge clk); #1;
        in0_valid = 1'b0;
        n_vec++;
        if (qa.size() == 0) begin
            n_err++;
            $display("FAIL idle_first: scoreboard empty");
        end else begin
            e = qa.pop_front();
            if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL idle_first: got v=%b src=%b data=%h want v=1 src=%b data=%h", a_v, a_s, a_d, e[32], e[31:0]);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (a_v !== 1'b0) begin
            n_err++;
            $display("FAIL idle_gap: got v=%b want 0", a_v);
        end
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 32'h66666666;
        in1_data  = 32'h77777777;
        #1;
        n_vec++;
        if ({a_r0, a_r1} !== 2'b01) begin
            n_err++;
            $display("FAIL idle_tie_ready: got %b%b want 01", a_r0, a_r1);
        end
        qa.push_back({1'b1, 32'h77777777});
        @(posedge clk); #1;
        n_vec++;
        if (qa.size() == 0) begin
            n_err++;
            $display("FAIL idle_tie_out: scoreboard empty");
        end else begin
            e = qa.pop_front();
            if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL idle_tie_out: got v=%b src=%b data=%h want v=1 src=%b data=%h", a_v, a_s, a_d, e[32], e[31:0]);
            end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [32:0] e;
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 32'h88888888;
        in1_data  = 32'h99999999;
        @(posedge clk); #1;
        n_vec++;
        if ({a_v, a_s, a_d} !== {1'b1, 1'b0, 32'h88888888}) begin
            n_err++;
            $display("FAIL midrst_loaded: got v=%b src=%b data=%h want v=1 src=0 data=88888888", a_v, a_s, a_d);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_v, a_s, a_d, a_r0, a_r1} !== '0) begin
            n_err++;
            $display("FAIL midrst_async: got v=%b src=%b data=%h rdy=%b%b want all zero", a_v, a_s, a_d, a_r0, a_r1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({a_r0, a_r1} !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_release_ready: got %b%b want 00", a_r0, a_r1);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({a_r0, a_r1} !== 2'b10) begin
            n_err++;
            $display("FAIL midrst_tie_ready: got %b%b want 10", a_r0, a_r1);
        end
        qa.push_back({1'b0, 32'h88888888});
        @(posedge clk); #1;
        n_vec++;
        if (qa.size() == 0) begin
            n_err++;
            $display("FAIL midrst_tie_out: scoreboard empty");
        end else begin
            e = qa.pop_front();
            if ({a_v, a_s, a_d} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL midrst_tie_out: got v=%b src=%b data=%h want v=1 src=%b data=%h", a_v, a_s, a_d, e[32], e[31:0]);
            end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_idle_closes();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Two-requester round-robin arbiter that shares one SIZE-bit 2:1 mux datapath (yMux) between two valid/ready sources. It drives the mux select, captures the selected word into a single output register, and presents it downstream with a valid/ready handshake. A bounded-burst counter keeps the grant with one source for up to MAX_BURST back-to-back transfers before switching. It sits in front of any shared consumer (ALU operand port, register-file write port) that two producers contend for.

## Interface
- SIZE, 32, data width of each requester and the output
- MAX_BURST, 2, max consecutive transfers for one source while the other waits (>=1; 1 = strict alternation)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in0_valid / in1_valid  in  1  requester has a word
- in0_data / in1_data  in  SIZE  requester word
- in0_ready / in1_ready  out  1  word accepted this cycle when ready && valid
- out_valid  out  1  output register holds a word
- out_data  out  SIZE  registered selected word
- out_src  out  1  source of out_data (0 or 1)
- out_ready  in  1  downstream accepts when out_valid && out_ready

## Operation
- Internal state: cur (last granted source), cnt (transfers in current burst, width clog2(MAX_BURST+1)), output register (out_valid, out_data, out_src).
- accept = !out_valid || out_ready (output stage can load this cycle).
- Select sel, combinational: only in0_valid -> 0; only in1_valid -> 1; both -> cur if cnt < MAX_BURST, else !cur; neither -> no transfer.
- in{sel}_ready = accept && in{sel}_valid; other ready = 0. Never both readies high.
- Datapath: yMux #(SIZE) with inputs in0_data/in1_data, select sel; result loads out_data.
- On transfer (accept && any valid): out_data <= mux result, out_src <= sel, out_valid <= 1; if sel == cur then cnt <= min(cnt+1, MAX_BURST) else cur <= sel, cnt <= 1.
- Accept with no valid: out_valid <= 0, cnt <= MAX_BURST (burst closes; next tie goes to !cur).
- !accept (stall): all state holds; out_data/out_src stable while out_valid && !out_ready.
- Inputs must not be consumed when not granted; requester may drop valid at any time without penalty.

## Timing
- Reset (async, immediate on rst_n low): out_valid=0, out_data=0, out_src=0, cur=1, cnt=MAX_BURST; in0_ready/in1_ready are 0 while in reset. First tie after reset grants source 0.
- Latency: word accepted at edge N appears on out_data/out_valid after edge N; one transfer per cycle sustained when out_ready=1.
- Simultaneous drain and load: out_valid && out_ready && new valid -> register reloads same edge, out_valid stays 1.
- Reset mid-burst or mid-stall: held word discarded; no ready asserted until first edge after rst_n deasserts.
- cnt saturates at MAX_BURST; never wraps.

## Structure
- Shared package: SRC_0/SRC_1 source constants and the burst-counter width function; no typedefs needed.
- One sub-module: existing yMux #(SIZE) instance for data selection; arbitration, counter and output register inline.

## Test plan
- Reset: rst_n=0 with in0_valid=in1_valid=1 -> out_valid=0, out_data=0, out_src=0, both readies 0.
- Single source: in0_valid=1, in0_data=32'hA5A5A5A5, out_ready=1 -> in0_ready=1, next cycle out_valid=1, out_data=32'hA5A5A5A5, out_src=0.
- Contention, MAX_BURST=2, both valid, out_ready=1 for 6 cycles -> out_src sequence 0,0,1,1,0,0; MAX_BURST=1 -> 0,1,0,1,0,1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with both valid -> out_data/out_src unchanged, both readies 0; out_ready=1 -> drain and reload same edge.
- Idle closes burst: source 0 transfers once, one cycle with no valid, then both valid -> source 1 granted.
- Mid-operation reset: pull rst_n low while out_valid=1 mid-burst -> out_valid drops without clock edge; after release, tie grants source 0.
